keymgr_sideload_sched: RTL and testbench

// - Sequences set/clear of NumSlots sideload key slots (AES, KMAC, OTBN) owned by the key manager.
// - Serialises load requests from the keymgr FSM and clear requests from SW/escalation onto
//   per-slot set/set_en/clr strobes.
// - Before any clear it obtains fresh entropy through an EDN-style req/ack handshake.

---
 rtl/keymgr_sideload_sched_pkg.sv | 29 ++
 rtl/keymgr_sideload_sched_if.sv | 40 ++++
 rtl/keymgr_sideload_ent_timer.sv | 27 ++
 rtl/keymgr_sideload_sched.sv | 148 ++++++++++++++
 tb/tb_keymgr_sideload_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keymgr_sideload_sched_pkg.sv
// Shared types for the keymgr sideload key-slot scheduler.
// Slot count, slot index width, FSM states and one-hot helper.
package keymgr_sideload_sched_pkg;

  localparam int NumSlots = 3;
  localparam int SlotIdxW = $clog2(NumSlots);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENT,
    CLR,
    DONE
  } sideload_sched_state_e;

  typedef enum logic [SlotIdxW-1:0] {
    SlAes,
    SlKmac,
    SlOtbn
  } sideload_dest_e;

  function automatic logic [NumSlots-1:0] slot_oh(
    input logic [SlotIdxW-1:0] idx,
    input logic                en
  );
    return en ? (NumSlots'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/keymgr_sideload_sched_if.sv
// Request/strobe bundle between keymgr, SW/escalation, EDN and key slots.
// slave: the scheduler; master: the requesters and slots around it.
interface keymgr_sideload_sched_if;
  import keymgr_sideload_sched_pkg::*;

  logic                en_i;
  logic                load_req_i;
  logic [SlotIdxW-1:0] load_dest_i;
  logic                load_valid_i;
  logic                load_ack_o;
  logic                clr_req_i;
  logic [NumSlots-1:0] clr_sel_i;
  logic                clr_ack_o;
  logic                ent_req_o;
  logic                ent_ack_i;
  logic [NumSlots-1:0] slot_set_o;
  logic [NumSlots-1:0] slot_set_en_o;
  logic [NumSlots-1:0] slot_clr_o;
  logic                busy_o;
  logic                err_o;

  modport slave (
    input  en_i, load_req_i, load_dest_i,
    input  load_valid_i, clr_req_i, clr_sel_i,
    input  ent_ack_i,
    output load_ack_o, clr_ack_o, ent_req_o,
    output slot_set_o, slot_set_en_o,
    output slot_clr_o, busy_o, err_o
  );

  modport master (
    output en_i, load_req_i, load_dest_i,
    output load_valid_i, clr_req_i, clr_sel_i,
    output ent_ack_i,
    input  load_ack_o, clr_ack_o, ent_req_o,
    input  slot_set_o, slot_set_en_o,
    input  slot_clr_o, busy_o, err_o
  );

endinterface

// File: rtl/keymgr_sideload_ent_timer.sv
// Entropy wait timer: cleared by load_i, counts while cnt_en_i,
// expired_o high during the Timeout-th counted cycle.
module keymgr_sideload_ent_timer #(
  parameter int Timeout = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam int CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q;

  assign expired_o = (cnt_q == CntW'(Timeout - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/keymgr_sideload_sched.sv
// Sideload slot set/clear sequencer with EDN refresh before clears.
// KEYMGR_SIDELOAD_SCRUB_EN: en_i falling edge queues an all-slot clear.
module keymgr_sideload_sched
  import keymgr_sideload_sched_pkg::*;
#(
  parameter int EntTimeout = 16
) (
  input logic                    clk_i,
  input logic                    rst_i,
  keymgr_sideload_sched_if.slave bus
);

  localparam logic [SlotIdxW-1:0] LastIdx =
    SlotIdxW'(NumSlots - 1);

  sideload_sched_state_e state_q;
  logic [SlotIdxW-1:0]   idx_q;
  logic [SlotIdxW-1:0]   idx_nxt;
  logic [NumSlots-1:0]   sel_q;
  logic [NumSlots-1:0]   set_q;
  logic [NumSlots-1:0]   set_en_q;
  logic [NumSlots-1:0]   clr_q;
  logic                  int_q;
  logic                  load_ack_q;
  logic                  clr_ack_q;
  logic                  ent_req_q;
  logic                  err_q;
  logic                  tmo;
  logic                  dest_bad;
  logic                  scrub_pend;

  assign idx_nxt  = idx_q + 1'b1;
  assign dest_bad =
    ({{(32-SlotIdxW){1'b0}}, bus.load_dest_i} >= 32'(NumSlots));

  keymgr_sideload_ent_timer #(
    .Timeout (EntTimeout)
  ) u_ent_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (state_q != ENT),
    .cnt_en_i  (state_q == ENT),
    .expired_o (tmo)
  );

`ifdef KEYMGR_SIDELOAD_SCRUB_EN
  logic en_q;
  logic scrub_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      scrub_q <= 1'b0;
    end else begin
      en_q <= bus.en_i;
      if (en_q && !bus.en_i) begin
        scrub_q <= 1'b1;
      end else if (state_q == IDLE) begin
        scrub_q <= 1'b0;
      end
    end
  end

  assign scrub_pend = scrub_q;
`else
  assign scrub_pend = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sel_q      <= '0;
      int_q      <= 1'b0;
      set_q      <= '0;
      set_en_q   <= '0;
      clr_q      <= '0;
      load_ack_q <= 1'b0;
      clr_ack_q  <= 1'b0;
      ent_req_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      set_q      <= '0;
      set_en_q   <= '0;
      clr_q      <= '0;
      load_ack_q <= 1'b0;
      clr_ack_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (scrub_pend) begin
            state_q   <= ENT;
            ent_req_q <= 1'b1;
            sel_q     <= '1;
            int_q     <= 1'b1;
          end else if (bus.clr_req_i) begin
            state_q   <= ENT;
            ent_req_q <= 1'b1;
            sel_q     <= bus.clr_sel_i;
            int_q     <= 1'b0;
          end else if (bus.load_req_i) begin
            state_q    <= LOAD;
            load_ack_q <= 1'b1;
            if (dest_bad) begin
              err_q <= 1'b1;
            end else if (bus.en_i) begin
              set_q    <= slot_oh(bus.load_dest_i, 1'b1);
              set_en_q <= slot_oh(bus.load_dest_i,
                                  bus.load_valid_i);
            end
          end
        end
        LOAD: state_q <= IDLE;
        ENT: begin
          // A late ack on the timeout cycle still counts as fresh
          if (bus.ent_ack_i || tmo) begin
            state_q   <= CLR;
            ent_req_q <= 1'b0;
            idx_q     <= '0;
            clr_q     <= slot_oh('0, sel_q[0]);
            if (!bus.ent_ack_i) err_q <= 1'b1;
          end
        end
        CLR: begin
          if (idx_q == LastIdx) begin
            state_q   <= DONE;
            clr_ack_q <= !int_q;
          end else begin
            idx_q <= idx_nxt;
            clr_q <= slot_oh(idx_nxt, sel_q[idx_nxt]);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Set strobes follow en_i live so a drop during LOAD kills them
  assign bus.slot_set_o    = set_q & {NumSlots{bus.en_i}};
  assign bus.slot_set_en_o = set_en_q & {NumSlots{bus.en_i}};
  assign bus.slot_clr_o    = clr_q;
  assign bus.load_ack_o    = load_ack_q;
  assign bus.clr_ack_o     = clr_ack_q;
  assign bus.ent_req_o     = ent_req_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_keymgr_sideload_sched.sv
// Self-checking bench for keymgr_sideload_sched.
// Load vectors from a table, clears via hand-written sequences.
module tb_keymgr_sideload_sched;
  import keymgr_sideload_sched_pkg::*;

  localparam int EntTo = 16;

  typedef struct {
    logic [1:0] dest;
    logic       valid;
    logic       en;
    logic [2:0] exp_set;
    logic [2:0] exp_set_en;
    logic       exp_err;
  } load_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  load_vec_t  vecs[7];
  load_vec_t  ldq[$];
  logic [2:0] clrq[$];

  keymgr_sideload_sched_if bus ();

  keymgr_sideload_sched #(
    .EntTimeout (EntTo)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {19'd0, bus.load_ack_o, bus.clr_ack_o,
            bus.ent_req_o, bus.slot_set_o,
            bus.slot_set_en_o, bus.slot_clr_o,
            bus.busy_o, bus.err_o};
  endfunction

  task automatic do_load(input load_vec_t v);
    int lat;
    load_vec_t e;
    @(negedge clk);
    bus.en_i = v.en;
    bus.load_req_i = 1'b1;
    bus.load_dest_i = v.dest;
    bus.load_valid_i = v.valid;
    ldq.push_back(v);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.load_ack_o && lat < 8);
    chk("load_latency", lat, 1);
    e = ldq.pop_front();
    chk("load_set", bus.slot_set_o, e.exp_set);
    chk("load_set_en", bus.slot_set_en_o, e.exp_set_en);
    chk("load_err", bus.err_o, e.exp_err);
    chk("load_no_clr", bus.slot_clr_o, 0);
    bus.load_req_i = 1'b0;
    @(negedge clk);
    chk("load_ack_pulse", bus.load_ack_o, 0);
    chk("load_idle", bus.busy_o, 0);
    bus.en_i = 1'b1;
  endtask

  task automatic run_clear(input logic [2:0] sel,
                           input int ack_after,
                           input bit tmo,
                           input logic exp_err,
                           input bit with_load);
    int n;
    logic [2:0] e;
    @(negedge clk);
    bus.clr_req_i = 1'b1;
    bus.clr_sel_i = sel;
    if (with_load) begin
      bus.load_req_i = 1'b1;
      bus.load_dest_i = 2'd0;
      bus.load_valid_i = 1'b1;
    end
    n = 0;
    while (n < EntTo) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("ent_req_on", bus.ent_req_o, 1);
      if (!tmo && n == ack_after) begin
        bus.ent_ack_i = 1'b1;
        break;
      end
    end
    if (tmo) chk("ent_req_last", bus.ent_req_o, 1);
    for (int i = 0; i < NumSlots; i++)
      clrq.push_back(sel & (3'b001 << i));
    for (int i = 0; i < NumSlots; i++) begin
      @(negedge clk);
      bus.ent_ack_i = 1'b0;
      e = clrq.pop_front();
      chk("slot_clr", bus.slot_clr_o, e);
      chk("no_set_in_clr", bus.slot_set_o, 0);
      chk("no_ack_in_clr", bus.clr_ack_o, 0);
      if (i == 0) begin
        chk("ent_req_off", bus.ent_req_o, 0);
        chk("clr_err", bus.err_o, exp_err);
      end
    end
    @(negedge clk);
    chk("clr_ack", bus.clr_ack_o, 1);
    chk("done_no_clr", bus.slot_clr_o, 0);
    bus.clr_req_i = 1'b0;
    @(negedge clk);
    chk("clr_ack_pulse", bus.clr_ack_o, 0);
    chk("clr_idle", bus.busy_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd1, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0};
    vecs[3] = '{2'd2, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0};
    vecs[4] = '{2'd0, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0};
    vecs[5] = '{2'd3, 1'b1, 1'b1, 3'b000, 3'b000, 1'b1};
    vecs[6] = '{2'd1, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1};

    bus.en_i = 1'b1;
    bus.load_req_i = 1'b0;
    bus.load_dest_i = '0;
    bus.load_valid_i = 1'b0;
    bus.clr_req_i = 1'b0;
    bus.clr_sel_i = '0;
    bus.ent_ack_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", all_out(), 0);

    foreach (vecs[i]) do_load(vecs[i]);

    do_reset();
    chk("reset_clears_err", bus.err_o, 0);

    run_clear(3'b101, 3, 1'b0, 1'b0, 1'b0);
    run_clear(3'b000, 1, 1'b0, 1'b0, 1'b0);
    run_clear(3'b011, 1, 1'b1, 1'b1, 1'b0);

    do_reset();
    run_clear(3'b110, 2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("coll_load_ack", bus.load_ack_o, 1);
    chk("coll_load_set", bus.slot_set_o, 3'b001);
    bus.load_req_i = 1'b0;
    @(negedge clk);
    chk("coll_ack_pulse", bus.load_ack_o, 0);

    // en_i dropping while in LOAD
    @(negedge clk);
    bus.load_req_i = 1'b1;
    bus.load_dest_i = 2'd1;
    bus.load_valid_i = 1'b1;
    @(negedge clk);
    bus.en_i = 1'b0;
    #1;
    chk("en_drop_ack", bus.load_ack_o, 1);
    chk("en_drop_set", bus.slot_set_o, 0);
    bus.load_req_i = 1'b0;
    bus.en_i = 1'b1;
    @(negedge clk);

    // reset during the clear walk aborts without ack
    @(negedge clk);
    bus.clr_req_i = 1'b1;
    bus.clr_sel_i = 3'b111;
    @(negedge clk);
    bus.ent_ack_i = 1'b1;
    @(negedge clk);
    bus.ent_ack_i = 1'b0;
    chk("mid_clr_strobe", bus.slot_clr_o, 3'b001);
    rst = 1'b1;
    bus.clr_req_i = 1'b0;
    @(negedge clk);
    chk("mid_clr_reset", all_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_abort", all_out(), 0);

`ifdef KEYMGR_SIDELOAD_SCRUB_EN
    begin
      int w;
      @(negedge clk);
      bus.en_i = 1'b0;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.ent_req_o && w < 6);
      chk("scrub_ent_req", bus.ent_req_o, 1);
      bus.ent_ack_i = 1'b1;
      for (int i = 0; i < NumSlots; i++) begin
        @(negedge clk);
        bus.ent_ack_i = 1'b0;
        chk("scrub_clr", bus.slot_clr_o, 3'b001 << i);
      end
      @(negedge clk);
      chk("scrub_no_ack", bus.clr_ack_o, 0);
      chk("scrub_done_busy", bus.busy_o, 1);
      @(negedge clk);
      chk("scrub_idle", bus.busy_o, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
